// File: rtl/bcd_updown_counter.sv
// ============================================================================
// bcd_updown_counter : multi-digit BCD up/down counter, load clamp, wrap flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_updown_counter #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_tick,
   input  logic                  i_en,
   input  logic                  i_mode,
   input  logic                  i_clear,
   input  logic                  i_load,
   input  logic [4*DIGITS-1:0]   i_load_bcd,
   output logic [4*DIGITS-1:0]   o_bcd,
   output logic                  o_wrap,
   output logic                  o_zero,
   output logic                  o_max
);

   localparam logic [3:0] c_nine = 4'd9;
   localparam logic [3:0] c_zero = 4'd0;

   logic [4*DIGITS-1:0] r_bcd;
   logic                r_wrap;
   logic [DIGITS:0]     w_lo_max;
   logic [DIGITS:0]     w_lo_zero;
   logic [4*DIGITS-1:0] w_up_bcd;
   logic [4*DIGITS-1:0] w_dn_bcd;
   logic [4*DIGITS-1:0] w_load_bcd;

   // w_lo_max[k] / w_lo_zero[k]: every digit below k is 9 / 0, i.e. digit k may move
   always_comb begin
      w_lo_max     = '0;
      w_lo_zero    = '0;
      w_lo_max[0]  = 1'b1;
      w_lo_zero[0] = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         w_lo_max[k+1]  = w_lo_max[k]  & (r_bcd[4*k +: 4] == c_nine);
         w_lo_zero[k+1] = w_lo_zero[k] & (r_bcd[4*k +: 4] == c_zero);
      end
   end

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_digit
         logic [3:0] w_d;
         logic [3:0] w_ld;
         assign w_d  = r_bcd[4*g +: 4];
         assign w_ld = i_load_bcd[4*g +: 4];

         assign w_up_bcd[4*g +: 4]   = !w_lo_max[g]  ? w_d :
                                       (w_d == c_nine) ? c_zero : w_d + 4'd1;
         assign w_dn_bcd[4*g +: 4]   = !w_lo_zero[g] ? w_d :
                                       (w_d == c_zero) ? c_nine : w_d - 4'd1;
         assign w_load_bcd[4*g +: 4] = (w_ld > c_nine) ? c_nine : w_ld;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_bcd  <= '0;
         r_wrap <= 1'b0;
      end else if (i_load) begin
         r_bcd  <= w_load_bcd;
         r_wrap <= 1'b0;
      end else if (i_en && i_tick) begin
         if (i_mode) begin
            r_bcd  <= w_dn_bcd;
            r_wrap <= w_lo_zero[DIGITS];
         end else begin
            r_bcd  <= w_up_bcd;
            r_wrap <= w_lo_max[DIGITS];
         end
      end else begin
         r_wrap <= 1'b0;
      end
   end

   assign o_bcd  = r_bcd;
   assign o_wrap = r_wrap;
   assign o_zero = (r_bcd == '0);
   assign o_max  = w_lo_max[DIGITS];

endmodule

`default_nettype wire

// File: tb/tb_bcd_updown_counter.sv
// ============================================================================
// tb_bcd_updown_counter : randomized + directed check of 1/4/6-digit counters
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bcd_updown_counter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_tick = 1'b0;
   logic        i_en = 1'b0;
   logic        i_mode = 1'b0;
   logic        i_clear = 1'b0;
   logic        i_load = 1'b0;
   logic [23:0] ld = '0;

   logic [3:0]  bcd1;
   logic [15:0] bcd4;
   logic [23:0] bcd6;
   logic [2:0]  wrap, zero, maxf;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   bcd_updown_counter #(.DIGITS(1)) u_d1 (
      .clk(clk), .rst(rst), .i_tick(i_tick), .i_en(i_en), .i_mode(i_mode),
      .i_clear(i_clear), .i_load(i_load), .i_load_bcd(ld[3:0]),
      .o_bcd(bcd1), .o_wrap(wrap[0]), .o_zero(zero[0]), .o_max(maxf[0]));

   bcd_updown_counter #(.DIGITS(4)) u_d4 (
      .clk(clk), .rst(rst), .i_tick(i_tick), .i_en(i_en), .i_mode(i_mode),
      .i_clear(i_clear), .i_load(i_load), .i_load_bcd(ld[15:0]),
      .o_bcd(bcd4), .o_wrap(wrap[1]), .o_zero(zero[1]), .o_max(maxf[1]));

   bcd_updown_counter #(.DIGITS(6)) u_d6 (
      .clk(clk), .rst(rst), .i_tick(i_tick), .i_en(i_en), .i_mode(i_mode),
      .i_clear(i_clear), .i_load(i_load), .i_load_bcd(ld),
      .o_bcd(bcd6), .o_wrap(wrap[2]), .o_zero(zero[2]), .o_max(maxf[2]));

   // Reference: each counter is a plain integer modulo 10^DIGITS
   int          dg  [3] = '{1, 4, 6};
   int unsigned md  [3] = '{10, 10000, 1000000};
   int unsigned mv  [3];
   bit          mw  [3];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] to_bcd(input int unsigned v, input int d);
      logic [31:0] r = '0;
      int unsigned x = v;
      for (int k = 0; k < d; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic int unsigned sanitize(input logic [23:0] raw, input int d);
      int unsigned v = 0, w = 1, dv;
      for (int k = 0; k < d; k++) begin
         dv = int'(raw[4*k +: 4]);
         if (dv > 9) dv = 9;
         v += dv * w;
         w *= 10;
      end
      return v;
   endfunction

   task automatic cycle();
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         if (rst || i_clear) begin
            mv[i] = 0; mw[i] = 0;
         end else if (i_load) begin
            mv[i] = sanitize(ld, dg[i]); mw[i] = 0;
         end else if (i_en && i_tick) begin
            if (i_mode) begin
               mw[i] = (mv[i] == 0);
               mv[i] = (mv[i] + md[i] - 1) % md[i];
            end else begin
               mw[i] = (mv[i] == md[i] - 1);
               mv[i] = (mv[i] + 1) % md[i];
            end
         end else begin
            mw[i] = 0;
         end
      end
      #1;
      check("bcd1", 32'(bcd1), to_bcd(mv[0], 1));
      check("bcd4", 32'(bcd4), to_bcd(mv[1], 4));
      check("bcd6", 32'(bcd6), to_bcd(mv[2], 6));
      for (int i = 0; i < 3; i++) begin
         check($sformatf("wrap%0d", dg[i]), 32'(wrap[i]), 32'(mw[i]));
         check($sformatf("zero%0d", dg[i]), 32'(zero[i]), 32'(mv[i] == 0));
         check($sformatf("max%0d", dg[i]),  32'(maxf[i]), 32'(mv[i] == md[i] - 1));
      end
   endtask

   task automatic drive(input logic r, input logic c, input logic l, input logic [23:0] v,
                        input logic e, input logic t, input logic m);
      rst = r; i_clear = c; i_load = l; ld = v; i_en = e; i_tick = t; i_mode = m;
      cycle();
   endtask

   initial begin
      foreach (mv[i]) begin mv[i] = 0; mw[i] = 0; end

      // Reset, then up-wrap over the full 4-digit range
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      check("rst_bcd4", 32'(bcd4), 32'h0);
      check("rst_zero4", 32'(zero[1]), 32'd1);
      check("rst_max4", 32'(maxf[1]), 32'd0);
      for (int n = 1; n <= 9999; n++) drive(0, 0, 0, 0, 1, 1, 0);
      check("up_9999", 32'(bcd4), 32'h9999);
      check("up_max", 32'(maxf[1]), 32'd1);
      drive(0, 0, 0, 0, 1, 1, 0);
      check("up_wrap_bcd", 32'(bcd4), 32'h0000);
      check("up_wrap", 32'(wrap[1]), 32'd1);
      drive(0, 0, 0, 0, 1, 0, 0);
      check("wrap_pulse_end", 32'(wrap[1]), 32'd0);

      // Down-borrow and down-wrap
      drive(0, 0, 1, 24'h001000, 1, 0, 1);
      drive(0, 0, 0, 0, 1, 1, 1);
      check("borrow", 32'(bcd4), 32'h0999);
      check("borrow_wrap", 32'(wrap[1]), 32'd0);
      drive(0, 0, 1, 24'h0, 1, 0, 1);
      drive(0, 0, 0, 0, 1, 1, 1);
      check("dn_wrap_bcd", 32'(bcd4), 32'h9999);
      check("dn_wrap", 32'(wrap[1]), 32'd1);

      // Load clamp beats tick; clear beats load
      drive(0, 0, 1, 24'h00A3F5, 1, 1, 0);
      check("clamp", 32'(bcd4), 32'h9395);
      drive(0, 1, 1, 24'h001234, 1, 1, 0);
      check("clear_wins", 32'(bcd4), 32'h0);

      // Enable/hold
      for (int n = 0; n < 42; n++) drive(0, 0, 0, 0, 1, 1, 0);
      for (int n = 0; n < 5; n++)  drive(0, 0, 0, 0, 0, 1, 0);
      check("hold", 32'(bcd4), 32'h0042);
      drive(0, 0, 0, 0, 1, 1, 0);
      check("resume", 32'(bcd4), 32'h0043);

      // Mode switching on back-to-back ticks
      drive(0, 0, 1, 24'h000010, 1, 0, 0);
      begin
         logic [15:0] exp_seq [5] = '{16'h0011, 16'h0012, 16'h0011, 16'h0010, 16'h0009};
         logic        mseq    [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
         for (int n = 0; n < 5; n++) begin
            drive(0, 0, 0, 0, 1, 1, mseq[n]);
            check($sformatf("mode_seq%0d", n), 32'(bcd4), 32'(exp_seq[n]));
         end
      end

      // Down-wrap from reset for the 1- and 6-digit variants, mid-count reset
      drive(1, 0, 0, 0, 1, 1, 0);
      drive(0, 0, 0, 0, 1, 1, 1);
      check("d1_dnwrap", 32'(bcd1), 32'h9);
      check("d6_dnwrap", 32'(bcd6), 32'h999999);
      check("d6_dnwrap_flag", 32'(wrap[2]), 32'd1);
      drive(0, 0, 0, 0, 1, 1, 0);
      check("d6_upwrap", 32'(bcd6), 32'h0);
      check("d1_upwrap_flag", 32'(wrap[0]), 32'd1);
      for (int n = 0; n < 7; n++) drive(0, 0, 0, 0, 1, 1, 0);
      drive(1, 0, 0, 0, 1, 1, 0);
      check("midrst_bcd6", 32'(bcd6), 32'h0);
      check("midrst_zero6", 32'(zero[2]), 32'd1);

      // Randomized traffic
      for (int n = 0; n < 4000; n++) begin
         drive(($urandom % 128) == 0, ($urandom % 64) == 0, ($urandom % 16) == 0,
               24'($urandom), ($urandom % 4) != 0, ($urandom % 2) == 0, 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit decimal up/down counter. It is the successor to the fixed 4-digit 0–9999 counter and drives the FND display path directly with packed BCD digits. It adds the following over that counter:
- digit count set by parameter
- synchronous load with digit sanitising
- hold/enable control
- wrap pulse and zero/max status flags

It sits between the tick generator and the FND controller.

## Interface
Parameters:
- `DIGITS`, default 4: number of decimal digits. Range 1–8. Count range is 0 .. 10^DIGITS−1.

Ports:
- `clk` in 1: system clock. All logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `i_tick` in 1: count strobe, one `clk` wide. Ignored while `i_en`=0.
- `i_en` in 1: count enable (run/hold). Does not gate clear or load.
- `i_mode` in 1: 0 = count up, 1 = count down. Sampled on the tick cycle.
- `i_clear` in 1: synchronous clear to 0.
- `i_load` in 1: synchronous load of `i_load_bcd`.
- `i_load_bcd` in 4*DIGITS: packed BCD load value. Digit 0 is in [3:0].
- `o_bcd` out 4*DIGITS: packed BCD count, registered. Digit 0 is in [3:0].
- `o_wrap` out 1: one-cycle pulse on wrap-around, registered.
- `o_zero` out 1: high when `o_bcd` is all zeros. Decoded from the count register.
- `o_max` out 1: high when every digit is 9. Decoded from the count register.

## Operation
- Action priority, evaluated each rising edge: `rst` > `i_clear` > `i_load` > (`i_en` & `i_tick`) > hold.
- `rst` or `i_clear`:
  - `o_bcd` ← 0, `o_wrap` ← 0.
- Load:
  - Each digit is loaded from `i_load_bcd`.
  - A digit value of 10–15 is clamped to 9.
  - `o_wrap` ← 0.
- Count up, `i_mode`=0:
  - Digit 0 increments.
  - A digit at 9 becomes 0 and carries into the next digit.
  - Each digit k advances only when all lower digits are 9.
- Count down, `i_mode`=1:
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - Each digit k advances only when all lower digits are 0.
- Wrap:
  - Up from all-9s gives all zeros. Down from all zeros gives all-9s.
  - `o_wrap` ← 1 for exactly that update. Otherwise `o_wrap` ← 0 on every edge.
- Hold: when no action applies, `o_bcd` is unchanged and `o_wrap` ← 0.
- `i_mode` may change on any cycle. Only its value on a tick cycle has effect, so there is no history.
- Digits are never outside 0–9 after reset, whatever the input sequence.
- The carry/borrow chain is purely combinational within the cycle. There is no per-digit pipelining.

## Timing
- Reset values: `o_bcd`=0, `o_wrap`=0, `o_zero`=1, `o_max`=0. For DIGITS≥1, `o_max`=0 because 0 ≠ 9.
- Latency:
  - Tick at edge N gives the new `o_bcd` visible after edge N. Latency is 1 cycle.
  - `o_wrap` is high in the same cycle as the wrapped value.
- Flags: `o_zero`/`o_max` follow `o_bcd` combinationally, with 0 additional latency.
- Back-to-back ticks on consecutive cycles are legal. Each one advances the count by exactly one.
- Simultaneous `i_clear` and `i_load`: clear wins.
- Simultaneous load and tick: the loaded value is taken and the tick is dropped. The count does not advance from the loaded value in that cycle.
- Reset asserted mid-count forces 0 at the next edge. Counting resumes on the first tick after `rst` deasserts.
- `i_tick` while `i_en`=0 is discarded. It is not queued.

## Test plan
- Reset, then up-wrap:
  - Stimulus: DIGITS=4, `rst` for 2 cycles, then `i_en`=1, `i_mode`=0, 10000 consecutive ticks.
  - Response: `o_bcd` reaches 16'h9999 after tick 9999 with `o_max`=1.
  - After tick 10000, `o_bcd`=16'h0000, `o_wrap`=1 for exactly 1 cycle, `o_zero`=1.
- Down-borrow:
  - Stimulus: load 16'h1000, `i_mode`=1, one tick.
  - Response: `o_bcd`=16'h0999, `o_wrap`=0.
  - Then load 0 and one tick: `o_bcd`=16'h9999, `o_wrap`=1.
- Load clamp and priority:
  - Stimulus: `i_load_bcd`=16'hA3F5 with `i_load`=1, `i_tick`=1 in the same cycle.
  - Response: `o_bcd`=16'h9395, tick ignored.
  - Next cycle with `i_clear`=1, `i_load`=1: `o_bcd`=0.
- Enable/hold:
  - Stimulus: count up to 16'h0042, then `i_en`=0 with 5 ticks.
  - Response: `o_bcd` stays 16'h0042.
  - Then `i_en`=1 with 1 tick: `o_bcd`=16'h0043.
- Mode switch with back-to-back ticks:
  - Stimulus: from 16'h0010, ticks on consecutive cycles with `i_mode` = 0, 0, 1, 1, 1.
  - Response: `o_bcd` = 0011, 0012, 0011, 0010, 0009.
- Parameter sweep:
  - Stimulus: DIGITS=1 and DIGITS=6, up-wrap and down-wrap from reset.
  - Response: DIGITS=1 wraps at 4'h9↔4'h0. DIGITS=6 wraps at 24'h999999↔0.
  - A mid-count `rst` returns `o_bcd`=0 with `o_zero`=1 on the next cycle.
